// File: rtl/fifo_ctrl.sv
// fifo_ctrl
//   Single-clock FIFO controller that drives an external dual-port RAM
//   whose write and read clocks are both tied to clk. The RAM's registered
//   read-data output is the FIFO output stage, so the head entry is presented
//   first-word-fall-through on m_data directly from ram_rdata.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   flush               synchronous clear of all contents
//   s_valid/s_ready     write handshake, s_data is the write data
//   m_valid/m_ready     read handshake, m_data is the head entry
//   ram_wenc/waddr/wdata  RAM write port controls
//   ram_renc/raddr        RAM read port controls
//   ram_rdata           RAM read data (one cycle read latency)
//   level               entries held (RAM plus output stage), 0..DEPTH+1
//   almost_full         level >= AF_LEVEL
//   almost_empty        level <= AE_LEVEL

module fifo_ctrl #(
    parameter int DEPTH    = 16,
    parameter int WIDTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             ram_wenc,
    output logic [AW-1:0]    ram_waddr,
    output logic [WIDTH-1:0] ram_wdata,
    output logic             ram_renc,
    output logic [AW-1:0]    ram_raddr,
    input  logic [WIDTH-1:0] ram_rdata,
    output logic [AW:0]      level,
    output logic             almost_full,
    output logic             almost_empty
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_LVL   = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_LVL   = (AW+1)'(AE_LEVEL);

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   ram_cnt;
    logic          rd_vld;
    logic          push;
    logic          pop;
    logic          renc;

    // Handshakes. s_ready depends only on the RAM count, never on m_ready,
    // so the write side has no combinational path from the read side.
    assign s_ready = !flush && (ram_cnt != CNT_FULL);
    assign push    = s_valid && s_ready;
    assign m_valid = rd_vld && !flush;
    assign pop     = m_valid && m_ready;

    // Fetch the next entry whenever the output stage is empty or is being
    // consumed this cycle. Only entries already counted in RAM are read, so
    // the read address never collides with a same-cycle write.
    assign renc = !flush && (ram_cnt != '0) && (!rd_vld || m_ready);

    assign ram_wenc  = push;
    assign ram_waddr = wptr;
    assign ram_wdata = s_data;
    assign ram_renc  = renc;
    assign ram_raddr = rptr;
    assign m_data    = ram_rdata;

    // Occupancy is taken from registered state only, so a flush request
    // does not disturb level or the almost flags in its own cycle.
    assign level        = ram_cnt + {{AW{1'b0}}, rd_vld};
    assign almost_full  = (level >= AF_LVL);
    assign almost_empty = (level <= AE_LVL);

    // Pointer, RAM count and output-stage valid registers. Flush returns
    // everything to the reset state at the next edge; RAM contents stay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            ram_cnt <= '0;
            rd_vld  <= 1'b0;
        end else if (flush) begin
            wptr    <= '0;
            rptr    <= '0;
            ram_cnt <= '0;
            rd_vld  <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (renc) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, renc})
                2'b10:   ram_cnt <= ram_cnt + (AW+1)'(1);
                2'b01:   ram_cnt <= ram_cnt - (AW+1)'(1);
                default: ram_cnt <= ram_cnt;
            endcase
            if (renc) begin
                rd_vld <= 1'b1;
            end else if (pop) begin
                rd_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl
//   Directed bench for fifo_ctrl with a behavioural dual-port RAM model
//   (registered read data, one cycle latency) attached to the RAM ports.

module tb_fifo_ctrl;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             ram_wenc;
    logic [AW-1:0]    ram_waddr;
    logic [WIDTH-1:0] ram_wdata;
    logic             ram_renc;
    logic [AW-1:0]    ram_raddr;
    logic [WIDTH-1:0] ram_rdata;
    logic [AW:0]      level;
    logic             almost_full;
    logic             almost_empty;

    logic [WIDTH-1:0] mem [DEPTH];

    int vectors    = 0;
    int miscompares = 0;

    fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .ram_wenc    (ram_wenc),
        .ram_waddr   (ram_waddr),
        .ram_wdata   (ram_wdata),
        .ram_renc    (ram_renc),
        .ram_raddr   (ram_raddr),
        .ram_rdata   (ram_rdata),
        .level       (level),
        .almost_full (almost_full),
        .almost_empty(almost_empty)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Behavioural dpram: synchronous write, registered read data.
    always @(posedge clk) begin
        if (ram_wenc) mem[ram_waddr] <= ram_wdata;
        if (ram_renc) ram_rdata <= mem[ram_raddr];
    end

    // Advance one clock; inputs are then driven 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
        step(); step();
        rst = 1'b0;
        #1;
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_m_valid: got %b want 0", m_valid); end
        vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_s_ready: got %b want 1", s_ready); end
        vectors++; if (level !== 5'd0) begin miscompares++; $display("[TB] FAIL reset_level: got %0d want 0", level); end
        vectors++; if (almost_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_almost_empty: got %b want 1", almost_empty); end
        vectors++; if (almost_full !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_almost_full: got %b want 0", almost_full); end
        vectors++; if (ram_renc !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_renc: got %b want 0", ram_renc); end
    endtask

    task automatic test_single_push();
        s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b0;
        #1;
        vectors++; if (ram_wenc !== 1'b1) begin miscompares++; $display("[TB] FAIL single_wenc: got %b want 1", ram_wenc); end
        vectors++; if (ram_waddr !== 4'd0) begin miscompares++; $display("[TB] FAIL single_waddr: got %0d want 0", ram_waddr); end
        step();
        s_valid = 1'b0;
        #1;
        vectors++; if (ram_renc !== 1'b1) begin miscompares++; $display("[TB] FAIL single_renc: got %b want 1", ram_renc); end
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_early_valid: got %b want 0", m_valid); end
        vectors++; if (level !== 5'd1) begin miscompares++; $display("[TB] FAIL single_level_ram: got %0d want 1", level); end
        step();
        vectors++; if (m_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL single_m_valid: got %b want 1", m_valid); end
        vectors++; if (m_data !== 8'hA5) begin miscompares++; $display("[TB] FAIL single_m_data: got %h want a5", m_data); end
        vectors++; if (level !== 5'd1) begin miscompares++; $display("[TB] FAIL single_level_out: got %0d want 1", level); end
        vectors++; if (ram_renc !== 1'b0) begin miscompares++; $display("[TB] FAIL single_renc_idle: got %b want 0", ram_renc); end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        #1;
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_pop_clear: got %b want 0", m_valid); end
        vectors++; if (level !== 5'd0) begin miscompares++; $display("[TB] FAIL single_pop_level: got %0d want 0", level); end
    endtask

    task automatic test_fill_drain();
        m_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            s_valid = 1'b1; s_data = 8'(i);
            #1;
            vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_accept_%0d: got %b want 1", i, s_ready); end
            step();
        end
        s_data = 8'h99;
        #1;
        vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL fill_full_ready: got %b want 0", s_ready); end
        vectors++; if (level !== 5'd17) begin miscompares++; $display("[TB] FAIL fill_level: got %0d want 17", level); end
        vectors++; if (almost_full !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_almost_full: got %b want 1", almost_full); end
        vectors++; if (almost_empty !== 1'b0) begin miscompares++; $display("[TB] FAIL fill_almost_empty: got %b want 0", almost_empty); end
        step();
        vectors++; if (level !== 5'd17) begin miscompares++; $display("[TB] FAIL fill_hold_level: got %0d want 17", level); end
        s_valid = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            #1;
            vectors++; if (m_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL drain_valid_%0d: got %b want 1", i, m_valid); end
            vectors++; if (m_data !== 8'(i)) begin miscompares++; $display("[TB] FAIL drain_data_%0d: got %0d want %0d", i, m_data, i); end
            vectors++; if (level !== 5'(17 - i)) begin miscompares++; $display("[TB] FAIL drain_level_%0d: got %0d want %0d", i, level, 17 - i); end
            if (i == 1) begin
                vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL drain_ready_resume: got %b want 1", s_ready); end
            end
            step();
        end
        m_ready = 1'b0;
        #1;
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL drain_empty_valid: got %b want 0", m_valid); end
        vectors++; if (level !== 5'd0) begin miscompares++; $display("[TB] FAIL drain_empty_level: got %0d want 0", level); end
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        for (int c = 0; c < 44; c++) begin
            s_valid = (c < 40); s_data = 8'(c); m_ready = 1'b1;
            #1;
            exp_v = (c >= 2) && (c < 42);
            vectors++; if (m_valid !== exp_v) begin miscompares++; $display("[TB] FAIL stream_valid_c%0d: got %b want %b", c, m_valid, exp_v); end
            if (exp_v) begin
                vectors++; if (m_data !== 8'(c - 2)) begin miscompares++; $display("[TB] FAIL stream_data_c%0d: got %0d want %0d", c, m_data, c - 2); end
            end
            vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL stream_ready_c%0d: got %b want 1", c, s_ready); end
            step();
        end
        s_valid = 1'b0; m_ready = 1'b0;
        #1;
        vectors++; if (level !== 5'd0) begin miscompares++; $display("[TB] FAIL stream_end_level: got %0d want 0", level); end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] q[$];
        logic [WIDTH-1:0] exp;
        for (int c = 0; c < 2000; c++) begin
            s_valid = 1'($urandom_range(0, 1));
            m_ready = 1'($urandom_range(0, 1));
            s_data  = 8'($urandom);
            #1;
            vectors++; if (level !== 5'(q.size())) begin miscompares++; $display("[TB] FAIL rand_level_c%0d: got %0d want %0d", c, level, q.size()); end
            if (m_valid && m_ready) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++; $display("[TB] FAIL rand_pop_empty_c%0d: got pop want none", c);
                end else begin
                    exp = q.pop_front();
                    if (m_data !== exp) begin miscompares++; $display("[TB] FAIL rand_data_c%0d: got %h want %h", c, m_data, exp); end
                end
            end
            if (s_valid && s_ready) q.push_back(s_data);
            step();
        end
        s_valid = 1'b0; m_ready = 1'b1;
        for (int c = 0; c < 60 && q.size() > 0; c++) begin
            #1;
            if (m_valid) begin
                exp = q.pop_front();
                vectors++; if (m_data !== exp) begin miscompares++; $display("[TB] FAIL rand_drain_data: got %h want %h", m_data, exp); end
            end
            step();
        end
        m_ready = 1'b0;
        #1;
        vectors++; if (q.size() != 0) begin miscompares++; $display("[TB] FAIL rand_drain_timeout: got %0d left want 0", q.size()); end
        vectors++; if (level !== 5'd0) begin miscompares++; $display("[TB] FAIL rand_drain_level: got %0d want 0", level); end
    endtask

    task automatic test_flush();
        bit seen;
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_data = 8'(8'h50 + i);
            step();
        end
        s_valid = 1'b1; m_ready = 1'b1; flush = 1'b1; s_data = 8'h77;
        #1;
        vectors++; if (level !== 5'd5) begin miscompares++; $display("[TB] FAIL flush_pre_level: got %0d want 5", level); end
        vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_s_ready: got %b want 0", s_ready); end
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_m_valid: got %b want 0", m_valid); end
        vectors++; if (ram_renc !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_renc: got %b want 0", ram_renc); end
        vectors++; if (ram_wenc !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_wenc: got %b want 0", ram_wenc); end
        step();
        flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        #1;
        vectors++; if (level !== 5'd0) begin miscompares++; $display("[TB] FAIL flush_post_level: got %0d want 0", level); end
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_post_valid: got %b want 0", m_valid); end
        vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_post_ready: got %b want 1", s_ready); end
        s_valid = 1'b1; s_data = 8'h3C;
        #1;
        vectors++; if (ram_waddr !== 4'd0) begin miscompares++; $display("[TB] FAIL flush_waddr: got %0d want 0", ram_waddr); end
        step();
        s_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            #1;
            if (m_valid) seen = 1'b1;
            else step();
        end
        vectors++; if (!seen) begin miscompares++; $display("[TB] FAIL flush_readback_timeout: got no m_valid want 1"); end
        vectors++; if (m_data !== 8'h3C) begin miscompares++; $display("[TB] FAIL flush_readback_data: got %h want 3c", m_data); end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = 8'(8'hC0 + i);
            step();
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_m_valid: got %b want 0", m_valid); end
        vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_s_ready: got %b want 1", s_ready); end
        vectors++; if (level !== 5'd0) begin miscompares++; $display("[TB] FAIL midrst_level: got %0d want 0", level); end
        vectors++; if (almost_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_almost_empty: got %b want 1", almost_empty); end
        s_valid = 1'b0;
        step();
        rst = 1'b0;
        #1;
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_after_valid: got %b want 0", m_valid); end
    endtask

    // Scenario sequence followed by the one-line summary.
    initial begin
        test_reset();
        test_single_push();
        test_fill_drain();
        test_back_to_back();
        test_random();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
